// File: rtl/vrf_pkg.sv
// Shared parameters, types and enumerations for the vector register file
// write sequencer.
package vrf_pkg;

  localparam int unsigned WIDTH        = 24;
  localparam int unsigned REGNUM       = 16;
  localparam int unsigned VECTOR_WIDTH = 8;
  localparam int unsigned REG_W        = $clog2(REGNUM);
  localparam int unsigned IDX_W        = $clog2(VECTOR_WIDTH);

  typedef logic [WIDTH-1:0] elem_t;
  typedef elem_t [VECTOR_WIDTH-1:0] vec_t;

  typedef enum logic [1:0] {IDLE, BURST, ELEM} seq_state_t;

  // Prefixed so the literals do not collide with the sequencer states.
  typedef enum logic {GNT_VEC, GNT_ELEM} grant_t;

endpackage

// File: rtl/vrf_write_sequencer_rr_arb2.sv
// Two-way round-robin arbiter between the vector and element writers.
// Each ready depends only on the other requester's valid.
module rr_arb2
  import vrf_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic req_vec,
  input  logic req_elem,
  output logic rdy_vec,
  output logic rdy_elem,
  output logic gnt_vec,
  output logic gnt_elem
);

  grant_t last_grant_q, last_grant_d;

  assign rdy_vec  = en && (!req_elem || (last_grant_q == GNT_ELEM));
  assign rdy_elem = en && (!req_vec  || (last_grant_q == GNT_VEC));
  assign gnt_vec  = req_vec  && rdy_vec;
  assign gnt_elem = req_elem && rdy_elem;

  always_comb begin
    last_grant_d = last_grant_q;
    if (gnt_vec) begin
      last_grant_d = GNT_VEC;
    end else if (gnt_elem) begin
      last_grant_d = GNT_ELEM;
    end
  end

  // Reset to ELEM so the first tie goes to the vector writer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= GNT_ELEM;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/vrf_write_sequencer.sv
// Write-port controller for the vector register file: arbitrates vector and
// element writers, bursts vectors element by element, steers reads when idle.
module vrf_write_sequencer
  import vrf_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          vec_valid,
  output logic                          vec_ready,
  input  logic [REG_W-1:0]              vec_reg,
  input  logic [VECTOR_WIDTH*WIDTH-1:0] vec_data,
  input  logic                          elem_valid,
  output logic                          elem_ready,
  input  logic [REG_W-1:0]              elem_reg,
  input  logic [IDX_W-1:0]              elem_index,
  input  logic [WIDTH-1:0]              elem_data,
  input  logic [REG_W-1:0]              rd_reg,
  input  logic [IDX_W-1:0]              rd_index,
  output logic                          rd_stall,
  output logic                          rf_we,
  output logic [REG_W-1:0]              rf_reg_num,
  output logic [IDX_W-1:0]              rf_index,
  output logic [WIDTH-1:0]              rf_data_in,
  output logic                          busy,
  output logic                          done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VECTOR_WIDTH - 1);

  seq_state_t       state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  vec_t             vec_q, vec_d;
  logic             we_q, we_d;
  logic             done_q, done_d;
  logic [REG_W-1:0] wr_reg_q, wr_reg_d;
  logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
  elem_t            wr_data_q, wr_data_d;

  vec_t             vec_in;
  logic [IDX_W-1:0] nxt_idx;
  logic             gnt_vec, gnt_elem;

  assign vec_in  = vec_data;
  assign nxt_idx = cnt_q + 1'b1;

  rr_arb2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (state_q == IDLE),
    .req_vec  (vec_valid),
    .req_elem (elem_valid),
    .rdy_vec  (vec_ready),
    .rdy_elem (elem_ready),
    .gnt_vec  (gnt_vec),
    .gnt_elem (gnt_elem)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    vec_d     = vec_q;
    we_d      = we_q;
    done_d    = 1'b0;
    wr_reg_d  = wr_reg_q;
    wr_idx_d  = wr_idx_q;
    wr_data_d = wr_data_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_vec) begin
          state_d   = BURST;
          vec_d     = vec_in;
          cnt_d     = '0;
          we_d      = 1'b1;
          wr_reg_d  = vec_reg;
          wr_idx_d  = '0;
          wr_data_d = vec_in[0];
        end else if (gnt_elem) begin
          state_d   = ELEM;
          we_d      = 1'b1;
          wr_reg_d  = elem_reg;
          wr_idx_d  = elem_index;
          wr_data_d = elem_data;
        end
      end
      BURST: begin
        // cnt_q tracks the element currently on the write port.
        if (cnt_q == LAST_IDX) begin
          state_d = IDLE;
          we_d    = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d     = nxt_idx;
          wr_idx_d  = nxt_idx;
          wr_data_d = vec_q[nxt_idx];
          done_d    = (nxt_idx == LAST_IDX);
        end
      end
      ELEM: begin
        state_d = IDLE;
        we_d    = 1'b0;
      end
      default: begin
        state_d = IDLE;
        we_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      vec_q     <= '0;
      we_q      <= 1'b0;
      done_q    <= 1'b0;
      wr_reg_q  <= '0;
      wr_idx_q  <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      vec_q     <= vec_d;
      we_q      <= we_d;
      done_q    <= done_d;
      wr_reg_q  <= wr_reg_d;
      wr_idx_q  <= wr_idx_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign rf_we      = we_q;
  assign rd_stall   = we_q;
  assign done       = done_q;
  assign busy       = (state_q != IDLE);
  assign rf_reg_num = we_q ? wr_reg_q : rd_reg;
  assign rf_index   = we_q ? wr_idx_q : rd_index;
  assign rf_data_in = wr_data_q;

endmodule

// File: tb/tb_vrf_write_sequencer.sv
// Randomised self-checking bench for vrf_write_sequencer against a
// transaction-level model (write schedule queue plus busy-until cycle).
module tb_vrf_write_sequencer;
  import vrf_pkg::*;

  logic                          clk;
  logic                          rst_n;
  logic                          vec_valid;
  logic                          vec_ready;
  logic [REG_W-1:0]              vec_reg;
  logic [VECTOR_WIDTH*WIDTH-1:0] vec_data;
  logic                          elem_valid;
  logic                          elem_ready;
  logic [REG_W-1:0]              elem_reg;
  logic [IDX_W-1:0]              elem_index;
  logic [WIDTH-1:0]              elem_data;
  logic [REG_W-1:0]              rd_reg;
  logic [IDX_W-1:0]              rd_index;
  logic                          rd_stall;
  logic                          rf_we;
  logic [REG_W-1:0]              rf_reg_num;
  logic [IDX_W-1:0]              rf_index;
  logic [WIDTH-1:0]              rf_data_in;
  logic                          busy;
  logic                          done;

  vrf_write_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .vec_valid  (vec_valid),
    .vec_ready  (vec_ready),
    .vec_reg    (vec_reg),
    .vec_data   (vec_data),
    .elem_valid (elem_valid),
    .elem_ready (elem_ready),
    .elem_reg   (elem_reg),
    .elem_index (elem_index),
    .elem_data  (elem_data),
    .rd_reg     (rd_reg),
    .rd_index   (rd_index),
    .rd_stall   (rd_stall),
    .rf_we      (rf_we),
    .rf_reg_num (rf_reg_num),
    .rf_index   (rf_index),
    .rf_data_in (rf_data_in),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: expected writes stamped with the cycle they must appear.
  typedef struct {
    int               cyc;
    logic [REG_W-1:0] r;
    logic [IDX_W-1:0] i;
    logic [WIDTH-1:0] d;
    bit               last;
  } wr_t;

  wr_t              exp_q[$];
  int               cyc;
  int               free_cyc;
  bit               last_vec;
  logic [WIDTH-1:0] last_data;
  bit               rnd_rd;

  task automatic model_reset();
    exp_q.delete();
    free_cyc  = cyc;
    last_vec  = 1'b0;
    last_data = '0;
  endtask

  task automatic rand_vec();
    vec_reg = REG_W'($urandom);
    for (int i = 0; i < VECTOR_WIDTH; i++) vec_data[i*WIDTH +: WIDTH] = WIDTH'($urandom);
  endtask

  task automatic rand_elem();
    elem_reg   = REG_W'($urandom);
    elem_index = IDX_W'($urandom);
    elem_data  = WIDTH'($urandom);
  endtask

  // Called just after a rising edge with inputs stable; checks at the falling edge.
  task automatic step(output bit acc_v, output bit acc_e);
    bit  idle, exp_vr, exp_er;
    wr_t w;
    @(negedge clk);
    idle   = (cyc >= free_cyc);
    exp_vr = idle && (!elem_valid || !last_vec);
    exp_er = idle && (!vec_valid || last_vec);
    check_val("vec_ready", vec_ready, exp_vr);
    check_val("elem_ready", elem_ready, exp_er);
    check_val("busy", busy, !idle);
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      w = exp_q.pop_front();
      check_val("rf_we", rf_we, 1'b1);
      check_val("rd_stall", rd_stall, 1'b1);
      check_val("wr_reg", rf_reg_num, w.r);
      check_val("wr_index", rf_index, w.i);
      check_val("wr_data", rf_data_in, w.d);
      check_val("done", done, w.last);
      last_data = w.d;
    end else begin
      check_val("rf_we_idle", rf_we, 1'b0);
      check_val("rd_stall_idle", rd_stall, 1'b0);
      check_val("rd_reg_pass", rf_reg_num, rd_reg);
      check_val("rd_index_pass", rf_index, rd_index);
      check_val("data_hold", rf_data_in, last_data);
      check_val("done_idle", done, 1'b0);
    end
    acc_v = vec_valid && exp_vr;
    acc_e = elem_valid && exp_er;
    if (acc_v) begin
      for (int i = 0; i < VECTOR_WIDTH; i++) begin
        w.cyc  = cyc + 1 + i;
        w.r    = vec_reg;
        w.i    = IDX_W'(i);
        w.d    = vec_data[i*WIDTH +: WIDTH];
        w.last = (i == VECTOR_WIDTH - 1);
        exp_q.push_back(w);
      end
      free_cyc = cyc + VECTOR_WIDTH + 1;
      last_vec = 1'b1;
    end else if (acc_e) begin
      w.cyc  = cyc + 1;
      w.r    = elem_reg;
      w.i    = elem_index;
      w.d    = elem_data;
      w.last = 1'b0;
      exp_q.push_back(w);
      free_cyc = cyc + 2;
      last_vec = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Accepted payloads are scrambled immediately so late input changes are exercised.
  task automatic run(input int n, input int pv, input int pe);
    bit av, ae;
    for (int k = 0; k < n; k++) begin
      step(av, ae);
      if (av) begin vec_valid  = 1'b0; rand_vec();  end
      if (ae) begin elem_valid = 1'b0; rand_elem(); end
      if (!vec_valid && ($urandom_range(99) < pv)) begin vec_valid = 1'b1; rand_vec(); end
      if (!elem_valid && ($urandom_range(99) < pe)) begin elem_valid = 1'b1; rand_elem(); end
      if (rnd_rd) begin
        rd_reg   = REG_W'($urandom);
        rd_index = IDX_W'($urandom);
      end
    end
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    vec_valid  = 1'b0;
    elem_valid = 1'b0;
    #1;
    check_val("rst_we", rf_we, 1'b0);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_done", done, 1'b0);
    check_val("rst_data", rf_data_in, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
  endtask

  initial begin
    bit av, ae;
    cyc    = 0;
    rnd_rd = 1'b0;
    rd_reg = 4'd1;
    rd_index = 3'd1;
    rand_vec();
    rand_elem();
    #2;
    do_reset();

    // Vector write to reg 5, lanes 1..8.
    vec_reg = 4'd5;
    for (int i = 0; i < VECTOR_WIDTH; i++) vec_data[i*WIDTH +: WIDTH] = WIDTH'(i + 1);
    vec_valid = 1'b1;
    run(12, 0, 0);

    // Single element write.
    elem_reg = 4'd3; elem_index = 3'd6; elem_data = 24'hABCDEF;
    elem_valid = 1'b1;
    run(4, 0, 0);

    // Vector write to reg 4 while a read of reg 9 / index 2 is held.
    rd_reg = 4'd9; rd_index = 3'd2;
    rand_vec();
    vec_reg = 4'd4;
    vec_valid = 1'b1;
    run(12, 0, 0);

    // Both requesters held from reset: strict alternation, vector first.
    do_reset();
    rand_vec(); rand_elem();
    vec_valid = 1'b1; elem_valid = 1'b1;
    run(50, 100, 100);

    // Reset during the fourth burst cycle, then an immediate new vector.
    do_reset();
    rand_vec();
    vec_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc && exp_q[0].i == 3'd3) break;
      step(av, ae);
      if (av) begin vec_valid = 1'b0; rand_vec(); end
    end
    check_val("mid_burst_reached", (exp_q.size() > 0) && (exp_q[0].i == 3'd3), 1'b1);
    check_val("mid_burst_we", rf_we, 1'b1);
    rst_n = 1'b0;
    #1;
    check_val("abort_we", rf_we, 1'b0);
    check_val("abort_busy", busy, 1'b0);
    check_val("abort_done", done, 1'b0);
    model_reset();
    rand_vec();
    vec_valid = 1'b1;
    #1;
    rst_n = 1'b1;
    step(av, ae);
    check_val("accept_after_abort", av, 1'b1);
    if (av) begin vec_valid = 1'b0; rand_vec(); end
    run(12, 0, 0);

    // Random traffic with a moving read address.
    rnd_rd = 1'b1;
    run(2000, 30, 30);
    rnd_rd = 1'b0;
    run(12, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
